// File: rtl/squarer_rr_sched.sv
// Round-robin front end sharing one 8-bit squarer datapath among NUM_REQ requesters.
// Returns square, requester ID and garbage-line popcount on one backpressured channel.
module squarer_rr_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_y,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_gones,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEval = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]       operand_q, operand_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_y_q, rsp_y_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_gones_q, rsp_gones_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             grant_window;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  grant_next;
    logic             accept;

    logic [55:0]      garbage_pp;
    logic [127:0]     garbage_sum;
    logic [15:0]      sq_y;
    logic [7:0]       sq_gones;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    // Squarer datapath: off-diagonal partial products and running row sums are the garbage lines.
    for (genvar i = 0; i < 8; i++) begin : g_pp_row
        for (genvar j = 0; j < 8; j++) begin : g_pp_col
            if (j != i) begin : g_pp
                assign garbage_pp[i*7 + (j < i ? j : j - 1)] = operand_q[i] & operand_q[j];
            end
        end
    end

    always_comb begin
        logic [15:0] acc;
        acc         = 16'h0000;
        garbage_sum = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            acc = acc + (operand_q[r] ? ({8'h00, operand_q} << r) : 16'h0000);
            garbage_sum[16*r +: 16] = acc;
        end
        sq_y = acc;
    end

    always_comb begin
        sq_gones = 8'h00;
        for (int unsigned k = 0; k < 56; k++) begin
            sq_gones = sq_gones + {7'b0, garbage_pp[k]};
        end
        for (int unsigned k = 0; k < 128; k++) begin
            sq_gones = sq_gones + {7'b0, garbage_sum[k]};
        end
    end

    // Arbiter: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned     idx_int;
        logic [ID_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_int     = 0;
        idx         = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx_int = (32'(rr_ptr_q) + off) % NUM_REQ;
            idx     = idx_int[ID_W-1:0];
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign grant_window = rst_int_n &&
                          ((state_q == StIdle) || ((state_q == StDone) && rsp_ready));
    assign accept       = grant_window && grant_found;
    assign req_ready    = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign grant_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        operand_d   = operand_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        rsp_gones_d = rsp_gones_q;
        op_count_d  = op_count_q;

        if (accept) begin
            operand_d = req_a[{grant_idx, 3'b000} +: 8];
            id_d      = grant_idx;
            rr_ptr_d  = grant_next;
        end

        case (state_q)
            StIdle: begin
                if (accept) state_d = StEval;
            end
            StEval: begin
                rsp_y_d     = sq_y;
                rsp_id_d    = id_q;
                rsp_gones_d = sq_gones;
                rsp_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (rsp_ready) begin
                    op_count_d  = op_count_q + CNT_W'(1);
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? StEval : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            operand_q   <= 8'h00;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= 16'h0000;
            rsp_id_q    <= '0;
            rsp_gones_q <= 8'h00;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            operand_q   <= operand_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rsp_gones_q <= rsp_gones_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gones = rsp_gones_q;
    assign busy      = (state_q != StIdle);
    assign op_count  = op_count_q;

endmodule
